// File: rtl/spi_rx_assembler.sv
// ---------------------------------------------------------------------------
// spi_rx_assembler
//
// Receive front end for one SPI channel. The asynchronous RX_* lines are
// brought into the CLK domain. MSB-first 16-bit words are assembled from them
// and stored in a show-ahead word FIFO. Every completed message has its word
// count queued for the slave-FIFO arbiter.
//
// Parameters
//   WORD_DEPTH : word FIFO depth in 16-bit words (power of 2)
//   LEN_DEPTH  : number of queued message lengths (power of 2, >= 2)
//
// Ports
//   CLK          in   system clock
//   RST          in   synchronous active-high reset
//   RX_CLK       in   async serial clock, data taken on its rising edge
//   RX_DATA      in   async serial data, MSB first
//   RX_LOAD      in   async word frame, high while words are shifted
//   RX_STOP      in   async end of message, rising edge closes the message
//   RD_REQ       in   pop the head word
//   RD_REQ_LEN   in   pop the head message length
//   FIFO_Q       out  head word (show-ahead, holds last value when empty)
//   GOT_FULL_MSG out  at least one completed message is queued
//   MSG_LEN      out  word count of the head message
//   OVERFLOW     out  sticky, at least one word was dropped
// ---------------------------------------------------------------------------
module spi_rx_assembler #(
    parameter int WORD_DEPTH = 256,
    parameter int LEN_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX_CLK,
    input  logic        RX_DATA,
    input  logic        RX_LOAD,
    input  logic        RX_STOP,
    input  logic        RD_REQ,
    input  logic        RD_REQ_LEN,
    output logic [15:0] FIFO_Q,
    output logic        GOT_FULL_MSG,
    output logic [7:0]  MSG_LEN,
    output logic        OVERFLOW
);

    localparam int WAW = $clog2(WORD_DEPTH);
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam logic [WAW:0] W_FULL_CNT = (WAW + 1)'(WORD_DEPTH);
    localparam logic [LAW:0] L_FULL_CNT = (LAW + 1)'(LEN_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronizer bit order: {STOP, LOAD, DATA, CLK}
    logic [3:0]     r_sync1;
    logic [3:0]     r_sync2;
    logic [1:0]     r_sync3;      // {STOP, CLK}: edge-detected lines only
    logic           w_clk_rise;
    logic           w_stop_rise;
    logic           w_load;
    logic           w_data;

    state_t         r_state;
    state_t         w_state_next;
    logic           w_shift_en;
    logic           w_cnt_clr;
    logic [3:0]     r_bit_cnt;
    logic [14:0]    r_shift;
    logic           r_commit_pend;
    logic [15:0]    r_commit_word;

    logic [7:0]     r_cur_len;
    logic [7:0]     w_len_inc;
    logic           w_commit_ok;
    logic           w_commit_drop;
    logic           w_len_push;
    logic           r_overflow;

    logic [15:0]    r_wmem [WORD_DEPTH];
    logic [WAW-1:0] r_wwr;
    logic [WAW-1:0] r_wrd;
    logic [WAW-1:0] w_wrd_inc;
    logic [WAW:0]   r_wcnt;
    logic           w_wfull;
    logic           w_wempty;
    logic           w_wpop;
    logic [15:0]    r_q;

    logic [7:0]     r_lmem [LEN_DEPTH];
    logic [LAW-1:0] r_lwr;
    logic [LAW-1:0] r_lrd;
    logic [LAW-1:0] w_lrd_next;
    logic [LAW:0]   r_lcnt;
    logic [LAW:0]   w_lcnt_next;
    logic           w_lfull;
    logic           w_lempty;
    logic           w_lpop;
    logic [7:0]     w_head_next;
    logic           r_got;
    logic [7:0]     r_msg_len;

    // Two-stage synchronizers plus a third stage for edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
            r_sync3 <= 2'b00;
        end else begin
            r_sync1 <= {RX_STOP, RX_LOAD, RX_DATA, RX_CLK};
            r_sync2 <= r_sync1;
            r_sync3 <= {r_sync2[3], r_sync2[0]};
        end
    end

    assign w_clk_rise  = r_sync2[0] & ~r_sync3[0];
    assign w_stop_rise = r_sync2[3] & ~r_sync3[1];
    assign w_load      = r_sync2[2];
    assign w_data      = r_sync2[1];

    // Word FSM next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_cnt_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next = ST_SHIFT;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Dropping the frame abandons any partial word
                if (!w_load) begin
                    w_state_next = ST_IDLE;
                end else if (w_clk_rise) begin
                    w_shift_en = 1'b1;
                end else begin
                    w_shift_en = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, bit counter, shift register and one-cycle commit stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 4'd0;
            r_shift       <= 15'd0;
            r_commit_pend <= 1'b0;
            r_commit_word <= 16'd0;
        end else begin
            r_state       <= w_state_next;
            r_commit_pend <= 1'b0;
            if (w_cnt_clr) begin
                r_bit_cnt <= 4'd0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[13:0], w_data};
                r_bit_cnt <= r_bit_cnt + 4'd1;   // wraps to 0 after bit 16
                if (r_bit_cnt == 4'd15) begin
                    r_commit_pend <= 1'b1;
                    r_commit_word <= {r_shift, w_data};
                end
            end
        end
    end

    assign w_wfull  = (r_wcnt == W_FULL_CNT);
    assign w_wempty = (r_wcnt == '0);
    assign w_lfull  = (r_lcnt == L_FULL_CNT);
    assign w_lempty = (r_lcnt == '0);
    assign w_wpop   = RD_REQ & ~w_wempty;
    assign w_lpop   = RD_REQ_LEN & ~w_lempty;

    // A full length queue can only occur with cur_len at 0, so dropping here
    // guarantees a free slot whenever a STOP has something to push.
    assign w_commit_ok   = r_commit_pend & ~w_wfull & (r_cur_len != 8'd255) & ~w_lfull;
    assign w_commit_drop = r_commit_pend & ~w_commit_ok;
    // Count the word first so a commit coinciding with STOP is included
    assign w_len_inc     = r_cur_len + {7'd0, w_commit_ok};
    assign w_len_push    = w_stop_rise & (w_len_inc != 8'd0) & ~w_lfull;

    // Current message length and sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cur_len  <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            r_cur_len  <= w_len_push ? 8'd0 : w_len_inc;
            r_overflow <= r_overflow | w_commit_drop;
        end
    end

    // Word FIFO storage (no reset; validity is tracked by the pointers)
    always_ff @(posedge CLK) begin
        if (w_commit_ok) begin
            r_wmem[r_wwr] <= r_commit_word;
        end
    end

    assign w_wrd_inc = r_wrd + WAW'(1);

    // Word FIFO pointers, occupancy and registered show-ahead head word
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wwr  <= '0;
            r_wrd  <= '0;
            r_wcnt <= '0;
            r_q    <= 16'd0;
        end else begin
            if (w_commit_ok) begin
                r_wwr <= r_wwr + WAW'(1);
            end
            if (w_wpop) begin
                r_wrd <= w_wrd_inc;
            end
            case ({w_commit_ok, w_wpop})
                2'b10:   r_wcnt <= r_wcnt + (WAW + 1)'(1);
                2'b01:   r_wcnt <= r_wcnt - (WAW + 1)'(1);
                default: r_wcnt <= r_wcnt;
            endcase
            // On a pop the following entry is already stored, so it is shown
            // immediately; a pop that empties the FIFO keeps the old word.
            if (w_wpop) begin
                if (r_wcnt > (WAW + 1)'(1)) begin
                    r_q <= r_wmem[w_wrd_inc];
                end
            end else if (!w_wempty) begin
                r_q <= r_wmem[r_wrd];
            end
        end
    end

    // Length queue occupancy after this cycle's push/pop
    always_comb begin
        w_lrd_next = w_lpop ? (r_lrd + LAW'(1)) : r_lrd;
        case ({w_len_push, w_lpop})
            2'b10:   w_lcnt_next = r_lcnt + (LAW + 1)'(1);
            2'b01:   w_lcnt_next = r_lcnt - (LAW + 1)'(1);
            default: w_lcnt_next = r_lcnt;
        endcase
    end

    // Head length after this cycle, bypassing a push into the head slot
    always_comb begin
        w_head_next = 8'd0;
        if (w_lcnt_next == '0) begin
            w_head_next = 8'd0;
        end else if (w_len_push && (r_lwr == w_lrd_next)) begin
            w_head_next = w_len_inc;
        end else begin
            w_head_next = r_lmem[w_lrd_next];
        end
    end

    // Length queue storage
    always_ff @(posedge CLK) begin
        if (w_len_push) begin
            r_lmem[r_lwr] <= w_len_inc;
        end
    end

    // Length queue pointers and registered head outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lwr     <= '0;
            r_lrd     <= '0;
            r_lcnt    <= '0;
            r_got     <= 1'b0;
            r_msg_len <= 8'd0;
        end else begin
            if (w_len_push) begin
                r_lwr <= r_lwr + LAW'(1);
            end
            r_lrd     <= w_lrd_next;
            r_lcnt    <= w_lcnt_next;
            r_got     <= (w_lcnt_next != '0);
            r_msg_len <= w_head_next;
        end
    end

    assign FIFO_Q       = r_q;
    assign GOT_FULL_MSG = r_got;
    assign MSG_LEN      = r_msg_len;
    assign OVERFLOW     = r_overflow;

endmodule

// File: tb/tb_spi_rx_assembler.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_assembler
//
// Directed bench for spi_rx_assembler. The SPI pins are driven at a slow
// serial rate of 4 CLK cycles per phase. Outputs are sampled on the falling
// CLK edge. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_spi_rx_assembler;

    localparam int HALF = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RX_CLK = 1'b0;
    logic        RX_DATA = 1'b0;
    logic        RX_LOAD = 1'b0;
    logic        RX_STOP = 1'b0;
    logic        RD_REQ = 1'b0;
    logic        RD_REQ_LEN = 1'b0;
    logic [15:0] FIFO_Q;
    logic        GOT_FULL_MSG;
    logic [7:0]  MSG_LEN;
    logic        OVERFLOW;

    int n_checks = 0;
    int n_errors = 0;

    spi_rx_assembler #(
        .WORD_DEPTH(256),
        .LEN_DEPTH (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_CLK      (RX_CLK),
        .RX_DATA     (RX_DATA),
        .RX_LOAD     (RX_LOAD),
        .RX_STOP     (RX_STOP),
        .RD_REQ      (RD_REQ),
        .RD_REQ_LEN  (RD_REQ_LEN),
        .FIFO_Q      (FIFO_Q),
        .GOT_FULL_MSG(GOT_FULL_MSG),
        .MSG_LEN     (MSG_LEN),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_q;
        logic [7:0]  exp_len;
        logic        exp_got;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        RX_DATA = b;
        RX_CLK  = 1'b0;
        tick(HALF);
        RX_CLK  = 1'b1;
        tick(HALF);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic msg_begin();
        RX_LOAD = 1'b1;
        tick(HALF);
    endtask

    task automatic msg_end();
        RX_CLK = 1'b0;
        tick(HALF);
        RX_LOAD = 1'b0;
        tick(HALF);
    endtask

    task automatic stop_pulse();
        RX_STOP = 1'b1;
        tick(6);
        RX_STOP = 1'b0;
        tick(4);
    endtask

    task automatic send_msg1(input logic [15:0] w);
        msg_begin();
        send_word(w);
        msg_end();
        stop_pulse();
    endtask

    task automatic pop_word();
        RD_REQ = 1'b1;
        tick(1);
        RD_REQ = 1'b0;
    endtask

    task automatic pop_len();
        RD_REQ_LEN = 1'b1;
        tick(1);
        RD_REQ_LEN = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_seq [5];

        vecs[0] = '{word: 16'h8001, exp_q: 16'h8001, exp_len: 8'd1, exp_got: 1'b1};
        vecs[1] = '{word: 16'h7FFE, exp_q: 16'h7FFE, exp_len: 8'd1, exp_got: 1'b1};
        vecs[2] = '{word: 16'hFFFF, exp_q: 16'hFFFF, exp_len: 8'd1, exp_got: 1'b1};
        vecs[3] = '{word: 16'h0000, exp_q: 16'h0000, exp_len: 8'd1, exp_got: 1'b1};
        vecs[4] = '{word: 16'hA5A5, exp_q: 16'hA5A5, exp_len: 8'd1, exp_got: 1'b1};

        // Reset values
        tick(3);
        chk("rst_q", FIFO_Q, 16'h0000);
        chk("rst_got", GOT_FULL_MSG, 1'b0);
        chk("rst_len", MSG_LEN, 8'd0);
        chk("rst_ovf", OVERFLOW, 1'b0);
        RST = 1'b0;
        tick(2);

        // Single two-word message
        msg_begin();
        send_word(16'h1234);
        send_word(16'hABCD);
        msg_end();
        stop_pulse();
        chk("single_got", GOT_FULL_MSG, 1'b1);
        chk("single_len", MSG_LEN, 8'd2);
        chk("single_q0", FIFO_Q, 16'h1234);
        pop_word();
        chk("single_q1", FIFO_Q, 16'hABCD);
        pop_word();
        pop_len();
        chk("single_got_after", GOT_FULL_MSG, 1'b0);
        chk("single_ovf", OVERFLOW, 1'b0);

        // Table of one-word messages
        for (int v = 0; v < 5; v++) begin
            send_msg1(vecs[v].word);
            chk("vec_q", FIFO_Q, vecs[v].exp_q);
            chk("vec_len", MSG_LEN, vecs[v].exp_len);
            chk("vec_got", GOT_FULL_MSG, vecs[v].exp_got);
            pop_word();
            pop_len();
            chk("vec_got_after", GOT_FULL_MSG, 1'b0);
        end

        // Partial word followed by an empty STOP
        msg_begin();
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b1);
        end
        RX_LOAD = 1'b0;
        RX_CLK  = 1'b0;
        tick(8);
        stop_pulse();
        chk("partial_got", GOT_FULL_MSG, 1'b0);
        chk("partial_ovf", OVERFLOW, 1'b0);
        chk("partial_q_held", FIFO_Q, 16'hA5A5);
        send_msg1(16'h5A5A);
        chk("after_partial_q", FIFO_Q, 16'h5A5A);
        chk("after_partial_len", MSG_LEN, 8'd1);
        pop_word();
        pop_len();

        // Stream a second message while the first is being read
        msg_begin();
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        msg_end();
        stop_pulse();
        chk("rw_len1", MSG_LEN, 8'd3);
        chk("rw_q0", FIFO_Q, 16'h1111);
        exp_seq[0] = 16'h4444;
        exp_seq[1] = 16'h5555;
        exp_seq[2] = 16'h6666;
        exp_seq[3] = 16'h7777;
        exp_seq[4] = 16'h8888;
        fork
            begin
                msg_begin();
                for (int k = 0; k < 5; k++) begin
                    send_word(exp_seq[k]);
                end
                msg_end();
                stop_pulse();
            end
            begin
                tick(20);
                pop_word();
                chk("rw_q1", FIFO_Q, 16'h2222);
                tick(80);
                pop_word();
                chk("rw_q2", FIFO_Q, 16'h3333);
                tick(150);
                pop_word();
                chk("rw_q3", FIFO_Q, 16'h4444);
            end
        join
        chk("rw_got", GOT_FULL_MSG, 1'b1);
        chk("rw_len_before", MSG_LEN, 8'd3);
        pop_len();
        chk("rw_len_after", MSG_LEN, 8'd5);
        chk("rw_got_after", GOT_FULL_MSG, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("rw_seq", FIFO_Q, exp_seq[k]);
            pop_word();
        end
        pop_len();
        chk("rw_got_end", GOT_FULL_MSG, 1'b0);
        chk("rw_ovf", OVERFLOW, 1'b0);

        // Length queue full: fifth message dropped
        for (int m = 1; m <= 5; m++) begin
            send_msg1(16'(m));
        end
        chk("lq_got", GOT_FULL_MSG, 1'b1);
        chk("lq_ovf", OVERFLOW, 1'b1);
        for (int m = 1; m <= 4; m++) begin
            chk("lq_q", FIFO_Q, 32'(m));
            chk("lq_len", MSG_LEN, 8'd1);
            chk("lq_got_each", GOT_FULL_MSG, 1'b1);
            pop_word();
            pop_len();
        end
        chk("lq_got_end", GOT_FULL_MSG, 1'b0);
        chk("lq_q_end", FIFO_Q, 16'h0004);

        // Reset clears the sticky overflow
        do_reset();
        chk("rst2_q", FIFO_Q, 16'h0000);
        chk("rst2_ovf", OVERFLOW, 1'b0);
        tick(2);

        // 300-word message: length saturates at 255
        msg_begin();
        for (int i = 0; i < 300; i++) begin
            send_word(16'(i));
        end
        msg_end();
        stop_pulse();
        chk("big_got", GOT_FULL_MSG, 1'b1);
        chk("big_len", MSG_LEN, 8'd255);
        chk("big_ovf", OVERFLOW, 1'b1);
        for (int i = 0; i < 255; i++) begin
            chk("big_word", FIFO_Q, 32'(i));
            pop_word();
        end
        chk("big_q_held", FIFO_Q, 16'd254);
        pop_len();
        chk("big_got_end", GOT_FULL_MSG, 1'b0);

        // Reset in the middle of a word with a message already queued
        send_msg1(16'h1357);
        chk("mid_pre_got", GOT_FULL_MSG, 1'b1);
        chk("mid_pre_q", FIFO_Q, 16'h1357);
        msg_begin();
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1);
        end
        RX_CLK = 1'b0;
        tick(1);
        do_reset();
        chk("mid_rst_q", FIFO_Q, 16'h0000);
        chk("mid_rst_got", GOT_FULL_MSG, 1'b0);
        chk("mid_rst_len", MSG_LEN, 8'd0);
        chk("mid_rst_ovf", OVERFLOW, 1'b0);
        RX_LOAD = 1'b0;
        tick(8);
        send_msg1(16'hBEEF);
        chk("mid_post_q", FIFO_Q, 16'hBEEF);
        chk("mid_post_len", MSG_LEN, 8'd1);
        chk("mid_post_got", GOT_FULL_MSG, 1'b1);
        chk("mid_post_ovf", OVERFLOW, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
